// File: rtl/ifetch_buffer.sv
// ----------------------------------------------------------------------------
// ifetch_buffer
//   Instruction-fetch front end between PC calculation and decode. Walks a
//   sequential fetch PC, issues in-order word requests to instruction memory,
//   buffers returned words together with their PCs in a FIFO and presents
//   {pc, instr} to decode over valid/ready. A redirect flushes the FIFO,
//   discards every in-flight response and restarts fetch at the target.
//
//   Optional feature macro: IFB_BYPASS_EN
//     defined   : a response arriving while the FIFO is empty (and nothing is
//                 being dropped) is presented to decode in the same cycle and,
//                 if decode is ready, consumed without a FIFO write.
//     undefined : every response passes through the FIFO (1-cycle latency).
//
// Ports
//   clk            in   clock, all state updates on posedge
//   rst            in   synchronous active-high reset
//   redirect_valid in   1-cycle pulse: restart fetch at redirect_pc
//   redirect_pc    in   redirect target, bits [1:0] ignored
//   imem_req       out  request valid
//   imem_addr      out  request byte address (word aligned)
//   imem_gnt       in   request accepted when imem_req && imem_gnt
//   imem_rvalid    in   response valid, in request order
//   imem_rdata     in   response instruction word
//   dec_valid      out  {dec_pc, dec_instr} valid
//   dec_pc         out  PC of presented instruction
//   dec_instr      out  presented instruction
//   dec_ready      in   decode accepts when dec_valid && dec_ready
// ----------------------------------------------------------------------------
module ifetch_buffer #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MAX_OUTST = 2,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        dec_valid,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_instr,
    input  logic        dec_ready
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned TW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    localparam logic [CW-1:0] DEPTH_CW  = DEPTH[CW-1:0];
    localparam logic [CW:0]   DEPTH_CX  = DEPTH[CW:0];
    localparam logic [CW-1:0] OUTST_CAP = MAX_OUTST[CW-1:0];
    localparam logic [TW-1:0] TAG_LAST  = TW'(MAX_OUTST - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]   fetch_pc;
    logic [CW-1:0] outst;       // requests granted but not yet answered
    logic [CW-1:0] drop;        // stale responses still to be discarded
    logic [CW-1:0] count;       // FIFO occupancy
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          rst_q;

    logic [31:0]   fifo_pc    [DEPTH];
    logic [31:0]   fifo_instr [DEPTH];

    // In-order PC tags of live (non-stale) outstanding requests.
    logic [31:0]   tag_mem [MAX_OUTST];
    logic [TW-1:0] tag_wr;
    logic [TW-1:0] tag_rd;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic          grant;
    logic          resp_keep;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_empty;
    logic          fifo_full;
    logic          bypass;
    logic [31:0]   tag_pc;
    logic [CW:0]   credit_used;

    function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] p);
        if (p == TAG_LAST) begin
            return '0;
        end
        return p + TW'(1);
    endfunction

    assign fifo_empty  = (count == '0);
    assign fifo_full   = (count == DEPTH_CW);
    assign credit_used = {1'b0, outst} + {1'b0, count};

    // Outstanding plus buffered words never exceed DEPTH, so every response
    // that is kept always finds a free FIFO slot. The cycle right after
    // reset is held off as well.
    assign imem_req  = !rst && !rst_q && !redirect_valid &&
                       (outst < OUTST_CAP) && (credit_used < DEPTH_CX);
    assign imem_addr = fetch_pc;
    assign grant     = imem_req && imem_gnt;

    // A response is delivered only when nothing stale is still in flight and
    // no redirect is discarding it in this very cycle.
    assign resp_keep = imem_rvalid && !rst && !redirect_valid && (drop == '0);
    assign tag_pc    = tag_mem[tag_rd];

`ifdef IFB_BYPASS_EN
    assign bypass = resp_keep && fifo_empty;
`else
    assign bypass = 1'b0;
`endif

    assign dec_valid = !rst && (!fifo_empty || bypass);

    always_comb begin
        dec_pc    = '0;
        dec_instr = '0;
        if (!rst && !fifo_empty) begin
            dec_pc    = fifo_pc[rd_ptr];
            dec_instr = fifo_instr[rd_ptr];
        end else if (bypass) begin
            dec_pc    = tag_pc;
            dec_instr = imem_rdata;
        end
    end

    // A bypassed word that decode takes immediately never touches the FIFO.
    assign fifo_pop  = dec_valid && dec_ready && !redirect_valid && !fifo_empty;
    assign fifo_push = resp_keep && !(bypass && dec_ready);

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            fetch_pc <= RESET_PC;
            outst    <= '0;
            drop     <= '0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            tag_wr   <= '0;
            tag_rd   <= '0;
        end else begin
            if (grant && !imem_rvalid) begin
                outst <= outst + CW'(1);
            end else if (!grant && imem_rvalid) begin
                outst <= outst - CW'(1);
            end

            if (redirect_valid) begin
                // Everything still in flight becomes stale; a response landing
                // in this same cycle is discarded here and not counted again.
                fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
                drop     <= imem_rvalid ? (outst - CW'(1)) : outst;
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                tag_wr   <= '0;
                tag_rd   <= '0;
            end else begin
                if (grant) begin
                    fetch_pc <= fetch_pc + 32'd4;
                    tag_wr   <= tag_next(tag_wr);
                end

                if (imem_rvalid) begin
                    if (drop != '0) begin
                        drop <= drop - CW'(1);
                    end else begin
                        tag_rd <= tag_next(tag_rd);
                    end
                end

                if (fifo_push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (fifo_pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end

                if (fifo_push && !fifo_pop) begin
                    count <= count + CW'(1);
                end else if (!fifo_push && fifo_pop) begin
                    count <= count - CW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage (no reset needed, validity tracked by pointers/counters)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_pc[wr_ptr]    <= tag_pc;
            fifo_instr[wr_ptr] <= imem_rdata;
        end
        if (grant) begin
            tag_mem[tag_wr] <= fetch_pc;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(fifo_push && fifo_full && !fifo_pop));
            assert (!(imem_rvalid && (outst == '0)));
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_buffer.sv
// ----------------------------------------------------------------------------
// tb_ifetch_buffer
//   Bench for ifetch_buffer (DEPTH=4, MAX_OUTST=2, RESET_PC=0). A behavioural
//   in-order instruction memory answers grants after a configurable latency;
//   expected {pc, instr} pairs are queued at grant time from the bench's own
//   fetch-PC model and compared at each decode handshake.
// ----------------------------------------------------------------------------
module tb_ifetch_buffer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        dec_valid;
    logic [31:0] dec_pc;
    logic [31:0] dec_instr;
    logic        dec_ready;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    ifetch_buffer #(
        .DEPTH     (4),
        .MAX_OUTST (2),
        .RESET_PC  (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .dec_valid      (dec_valid),
        .dec_pc         (dec_pc),
        .dec_instr      (dec_instr),
        .dec_ready      (dec_ready)
    );

`ifdef IFB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    // Memory model and scoreboard state
    logic [31:0] pend_addr [$];
    int          pend_due  [$];
    logic [63:0] exp_q     [$];
    logic [31:0] exp_fetch_pc = RESET_PC;
    int          cyc       = 0;
    int          last_due  = 0;
    int          lat_fixed = 1;
    bit          lat_rand  = 1'b0;

    // Per-step observations
    bit          gr;
    bit          hs;
    bit          obs_rvalid;
    bit          obs_dec_valid;
    logic [31:0] gr_addr;
    logic [31:0] hs_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // One clock: drive memory response, observe, update models, advance.
    task automatic step();
        int          e;
        int          l;
        int          due;
        logic [63:0] exp;
        e = cyc + 1;
        if (rst) begin
            pend_addr.delete();
            pend_due.delete();
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end else if (pend_due.size() > 0 && pend_due[0] <= e) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
        end
        #1;
        gr            = 1'b0;
        hs            = 1'b0;
        obs_rvalid    = imem_rvalid;
        obs_dec_valid = dec_valid;

        if (redirect_valid && !rst) begin
            tests_run++;
            if (imem_req !== 1'b0) begin
                tests_failed++;
                $display("FAIL req_during_redirect: imem_req=%b required 0", imem_req);
            end
        end

        if (!rst && imem_req && imem_gnt) begin
            gr      = 1'b1;
            gr_addr = imem_addr;
            tests_run++;
            if (imem_addr !== exp_fetch_pc) begin
                tests_failed++;
                $display("FAIL imem_addr: got %h required %h", imem_addr, exp_fetch_pc);
            end
            exp_q.push_back({exp_fetch_pc, mem_word(exp_fetch_pc)});
            l   = lat_rand ? int'($urandom_range(4, 1)) : lat_fixed;
            due = (e + l > last_due) ? e + l : last_due + 1;
            last_due = due;
            pend_addr.push_back(imem_addr);
            pend_due.push_back(due);
            exp_fetch_pc = exp_fetch_pc + 32'd4;
        end

        if (!rst && !redirect_valid && dec_valid && dec_ready) begin
            hs    = 1'b1;
            hs_pc = dec_pc;
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL dec_spurious: got pc=%h instr=%h, none expected", dec_pc, dec_instr);
            end else begin
                exp = exp_q.pop_front();
                if ({dec_pc, dec_instr} !== exp) begin
                    tests_failed++;
                    $display("FAIL dec_data: got pc=%h instr=%h required pc=%h instr=%h",
                             dec_pc, dec_instr, exp[63:32], exp[31:0]);
                end
            end
        end

        if (rst) begin
            exp_q.delete();
            exp_fetch_pc = RESET_PC;
            last_due     = e;
        end else if (redirect_valid) begin
            exp_q.delete();
            exp_fetch_pc = redirect_pc & 32'hFFFF_FFFC;
        end

        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic drain();
        imem_gnt       = 1'b0;
        dec_ready      = 1'b1;
        redirect_valid = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0 && pend_due.size() == 0) break;
            step();
        end
    endtask

    task automatic test_reset();
        bit found;
        rst = 1'b1; imem_gnt = 1'b1; dec_ready = 1'b1; lat_rand = 1'b0; lat_fixed = 1;
        step();
        step();
        tests_run++;
        if (imem_req !== 1'b0) begin
            tests_failed++; $display("FAIL reset_req: imem_req=%b required 0", imem_req);
        end
        tests_run++;
        if ({dec_valid, dec_pc, dec_instr} !== 65'd0) begin
            tests_failed++;
            $display("FAIL reset_dec: valid=%b pc=%h instr=%h required all 0", dec_valid, dec_pc, dec_instr);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if ({dec_valid, dec_pc, dec_instr} !== 65'd0) begin
            tests_failed++;
            $display("FAIL post_reset_dec: valid=%b pc=%h instr=%h required all 0", dec_valid, dec_pc, dec_instr);
        end
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (gr) begin found = 1'b1; break; end
        end
        tests_run++;
        if (!found) begin
            tests_failed++; $display("FAIL reset_first_grant: no grant, required addr %h", RESET_PC);
        end else if (gr_addr !== RESET_PC) begin
            tests_failed++; $display("FAIL reset_first_grant: got %h required %h", gr_addr, RESET_PC);
        end
        drain();
    endtask

    task automatic test_stream();
        int n;
        do_reset();
        lat_rand = 1'b0; lat_fixed = 1; imem_gnt = 1'b1; dec_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (hs) n++;
        end
        tests_run++;
        if (n !== 10) begin
            tests_failed++; $display("FAIL stream_rate: got %0d handshakes in 10 cycles required 10", n);
        end
        drain();
        tests_run++;
        if (exp_q.size() !== 0 || dec_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL stream_drain: left=%0d dec_valid=%b required 0/0", exp_q.size(), dec_valid);
        end
    endtask

    task automatic test_latency();
        bit found;
        do_reset();
        lat_rand = 1'b0; lat_fixed = 1; imem_gnt = 1'b1; dec_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (gr) begin found = 1'b1; break; end
        end
        step();
        tests_run++;
        if (!found || obs_rvalid !== 1'b1) begin
            tests_failed++; $display("FAIL lat_resp: rvalid=%b found=%b required 1/1", obs_rvalid, found);
        end
        tests_run++;
        if (obs_dec_valid !== BYP) begin
            tests_failed++; $display("FAIL lat_same_cycle: dec_valid=%b required %b", obs_dec_valid, BYP);
        end
        step();
        tests_run++;
        if (obs_dec_valid !== 1'b1) begin
            tests_failed++; $display("FAIL lat_next_cycle: dec_valid=%b required 1", obs_dec_valid);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int          n_gr;
        int          n_hs;
        logic [31:0] pcs [5];
        do_reset();
        lat_rand = 1'b0; lat_fixed = 1; imem_gnt = 1'b1; dec_ready = 1'b0;
        n_gr = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (gr) n_gr++;
        end
        tests_run++;
        if (n_gr !== 4) begin
            tests_failed++; $display("FAIL bp_grants: got %0d required 4", n_gr);
        end
        tests_run++;
        if (imem_req !== 1'b0 || dec_valid !== 1'b1 || dec_pc !== 32'h0) begin
            tests_failed++;
            $display("FAIL bp_hold: req=%b dec_valid=%b dec_pc=%h required 0/1/0", imem_req, dec_valid, dec_pc);
        end
        dec_ready = 1'b1;
        n_hs = 0;
        for (int i = 0; i < 40 && n_hs < 5; i++) begin
            step();
            if (hs) begin pcs[n_hs] = hs_pc; n_hs++; end
        end
        tests_run++;
        if (n_hs !== 5) begin
            tests_failed++; $display("FAIL bp_release: got %0d handshakes required 5", n_hs);
        end else begin
            for (int k = 0; k < 5; k++) begin
                tests_run++;
                if (pcs[k] !== 32'(4 * k)) begin
                    tests_failed++; $display("FAIL bp_order[%0d]: got %h required %h", k, pcs[k], 32'(4 * k));
                end
            end
        end
        drain();
        tests_run++;
        if (exp_q.size() !== 0 || dec_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_drain: left=%0d dec_valid=%b required 0/0", exp_q.size(), dec_valid);
        end
    endtask

    task automatic test_redirect_drain();
        int n;
        bit found;
        do_reset();
        lat_rand = 1'b0; lat_fixed = 3; imem_gnt = 1'b1; dec_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (gr) n++;
            if (n == 2) break;
        end
        tests_run++;
        if (n !== 2) begin
            tests_failed++; $display("FAIL rd_setup: got %0d grants required 2", n);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        step();
        redirect_valid = 1'b0;
        tests_run++;
        if (dec_valid !== 1'b0) begin
            tests_failed++; $display("FAIL rd_flush: dec_valid=%b required 0", dec_valid);
        end
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (gr) begin found = 1'b1; break; end
        end
        tests_run++;
        if (!found || gr_addr !== 32'h100) begin
            tests_failed++; $display("FAIL rd_addr: found=%b got %h required 00000100", found, gr_addr);
        end
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (hs) begin found = 1'b1; break; end
        end
        tests_run++;
        if (!found || hs_pc !== 32'h100) begin
            tests_failed++; $display("FAIL rd_dec_pc: found=%b got %h required 00000100", found, hs_pc);
        end
        drain();
        tests_run++;
        if (exp_q.size() !== 0) begin
            tests_failed++; $display("FAIL rd_drain: left=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_redirect_collide();
        bit found;
        do_reset();
        lat_rand = 1'b0; lat_fixed = 1; imem_gnt = 1'b1; dec_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();
        dec_ready = 1'b0;
        step();
        dec_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        step();
        redirect_valid = 1'b0;
        tests_run++;
        if (obs_rvalid !== 1'b1 || obs_dec_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL rc_setup: rvalid=%b dec_valid=%b required 1/1", obs_rvalid, obs_dec_valid);
        end
        tests_run++;
        if (dec_valid !== 1'b0) begin
            tests_failed++; $display("FAIL rc_flush: dec_valid=%b required 0", dec_valid);
        end
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (gr) begin found = 1'b1; break; end
        end
        tests_run++;
        if (!found || gr_addr !== 32'h200) begin
            tests_failed++; $display("FAIL rc_addr: found=%b got %h required 00000200", found, gr_addr);
        end
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (hs) begin found = 1'b1; break; end
        end
        tests_run++;
        if (!found || hs_pc !== 32'h200) begin
            tests_failed++; $display("FAIL rc_dec_pc: found=%b got %h required 00000200", found, hs_pc);
        end
        drain();
    endtask

    task automatic test_pc_wrap();
        int          n;
        logic [31:0] addrs [3];
        do_reset();
        lat_rand = 1'b0; lat_fixed = 1; imem_gnt = 1'b1; dec_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        step();
        redirect_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 20 && n < 3; i++) begin
            step();
            if (gr) begin addrs[n] = gr_addr; n++; end
        end
        tests_run++;
        if (n !== 3) begin
            tests_failed++; $display("FAIL wrap_grants: got %0d required 3", n);
        end else begin
            tests_run++;
            if (addrs[1] !== 32'hFFFF_FFFC || addrs[2] !== 32'h0000_0000) begin
                tests_failed++;
                $display("FAIL wrap_addr: got %h,%h required fffffffc,00000000", addrs[1], addrs[2]);
            end
        end
        drain();
        tests_run++;
        if (exp_q.size() !== 0) begin
            tests_failed++; $display("FAIL wrap_drain: left=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_midstream();
        bit found;
        do_reset();
        lat_rand = 1'b0; lat_fixed = 1; imem_gnt = 1'b1; dec_ready = 1'b0;
        for (int i = 0; i < 20; i++) step();
        tests_run++;
        if (dec_valid !== 1'b1) begin
            tests_failed++; $display("FAIL rm_full: dec_valid=%b required 1", dec_valid);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if ({dec_valid, dec_pc, dec_instr} !== 65'd0 || imem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL rm_in_reset: valid=%b pc=%h instr=%h req=%b required all 0",
                     dec_valid, dec_pc, dec_instr, imem_req);
        end
        step();
        rst = 1'b0;
        #1;
        tests_run++;
        if (dec_valid !== 1'b0) begin
            tests_failed++; $display("FAIL rm_after: dec_valid=%b required 0", dec_valid);
        end
        dec_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (gr) begin found = 1'b1; break; end
        end
        tests_run++;
        if (!found || gr_addr !== RESET_PC) begin
            tests_failed++; $display("FAIL rm_restart: found=%b got %h required %h", found, gr_addr, RESET_PC);
        end
        drain();
    endtask

    task automatic test_random();
        do_reset();
        lat_rand = 1'b1;
        for (int i = 0; i < 400; i++) begin
            imem_gnt       = ($urandom_range(9, 0) < 7);
            dec_ready      = ($urandom_range(9, 0) < 7);
            redirect_valid = ($urandom_range(39, 0) == 0);
            redirect_pc    = $urandom;
            step();
        end
        redirect_valid = 1'b0;
        drain();
        lat_rand = 1'b0;
        tests_run++;
        if (exp_q.size() !== 0 || dec_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rand_drain: left=%0d dec_valid=%b required 0/0", exp_q.size(), dec_valid);
        end
    endtask

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; dec_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_latency();
        test_backpressure();
        test_redirect_drain();
        test_redirect_collide();
        test_pc_wrap();
        test_reset_midstream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
